// File: rtl/conv_sched.sv
// Window scheduler for the 5x5 convolution datapath: row-major window issue, latency-matched valid pipe, credit-gated output FIFO.
// Optional: define CONV_SCHED_STALL_CNT_EN to add the stall_cnt port (RUN cycles blocked by credit).
module conv_sched #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = 5,
    parameter int PIPE_LAT   = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_W      = 21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       issue,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    input  logic signed [OUT_W-1:0]    sum_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_last
`ifdef CONV_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int IW   = $clog2(PIPE_LAT + 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - K);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - K);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [PIPE_LAT-1:0] vpipe, lpipe;
    logic [IW-1:0]       inflight;
    logic [CNTW-1:0]     fifo_count;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [OUT_W:0]      fifo_mem [FIFO_DEPTH];
    logic                credit_ok, last_win, fifo_wr, fifo_rd;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + IW'(vpipe[i]);
        end
    end

    // Every result still in the tree must already own a FIFO slot, since the tree cannot stall.
    assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign last_win  = (win_row == ROW_MAX) && (win_col == COL_MAX);
    assign fifo_wr   = vpipe[PIPE_LAT-1];
    assign out_valid = (fifo_count != '0);
    assign fifo_rd   = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_mem[rd_ptr][OUT_W-1:0] : '0;
    assign out_last  = out_valid && fifo_mem[rd_ptr][OUT_W];
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                issue = credit_ok;
                if (credit_ok && last_win) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fifo_rd && out_last && inflight == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            win_row <= '0;
            win_col <= '0;
            vpipe   <= '0;
            lpipe   <= '0;
        end else begin
            state <= state_nxt;
            vpipe <= (vpipe << 1) | PIPE_LAT'(issue);
            lpipe <= (lpipe << 1) | PIPE_LAT'(issue && last_win);
            if (state == IDLE && start) begin
                win_row <= '0;
                win_col <= '0;
            end else if (issue) begin
                if (last_win) begin
                    win_row <= '0;
                    win_col <= '0;
                end else if (win_col == COL_MAX) begin
                    win_col <= '0;
                    win_row <= win_row + 1'b1;
                end else begin
                    win_col <= win_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNTW'(fifo_wr) - CNTW'(fifo_rd);
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= {lpipe[PIPE_LAT-1], sum_in};
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr && !fifo_rd && fifo_count == CNTW'(FIFO_DEPTH)));

`ifdef CONV_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RUN && !issue && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: randomized ready/start stimulus against a window-order and credit model.
module tb_conv_sched;

    localparam int IMG_W = 32, IMG_H = 32, K = 5, PIPE_LAT = 5, FIFO_DEPTH = 8, OUT_W = 21;
    localparam int NCOL = IMG_W - K + 1;
    localparam int NWIN = (IMG_H - K + 1) * NCOL;

    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic signed [OUT_W-1:0] sum_in;
    logic busy, done, issue, out_valid, out_last;
    logic [$clog2(IMG_H)-1:0] win_row;
    logic [$clog2(IMG_W)-1:0] win_col;
    logic signed [OUT_W-1:0] out_data;
`ifdef CONV_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    conv_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIPE_LAT(PIPE_LAT),
                 .FIFO_DEPTH(FIFO_DEPTH), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .issue(issue),
        .win_row(win_row), .win_col(win_col), .sum_in(sum_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef CONV_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
    typedef struct {
        logic signed [OUT_W-1:0] data;
        bit                      last;
        int                      avail;
    } res_t;

    int n_cmp = 0, n_fail = 0;
    mstate_t ms = M_IDLE;
    res_t mq[$];
    res_t sched[int];
    int cyc = 0, issued = 0, popped = 0, frame_lasts = 0, frames_done = 0, stall_m = 0;
    int first_issue_cyc = 0, last_issue_cyc = 0, first_valid_cyc = 0;
    bit seen_valid = 0, spam = 0;
    int ready_mode = 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic resetModel();
        ms = M_IDLE;
        mq.delete();
        sched.delete();
        issued = 0;
        popped = 0;
        stall_m = 0;
    endtask

    // Model: windows in row-major order; a window may issue while fewer than FIFO_DEPTH results are unpopped.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_issue", issue, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_out_data", out_data, 0);
            checkOutput("rst_out_last", out_last, 0);
            checkOutput("rst_win_row", win_row, 0);
            checkOutput("rst_win_col", win_col, 0);
            resetModel();
            sum_in = OUT_W'($urandom);
        end else begin
            bit issue_e, ov_e, pop_e, done_e;
            res_t r;
            issue_e = (ms == M_RUN) && ((issued - popped) < FIFO_DEPTH);
            checkOutput("busy", busy, ms != M_IDLE);
            checkOutput("issue", issue, issue_e);
            if (issue_e) begin
                checkOutput("win_row", win_row, issued / NCOL);
                checkOutput("win_col", win_col, issued % NCOL);
                r.data = OUT_W'($urandom);
                r.last = (issued == NWIN - 1);
                r.avail = 0;
                sched[cyc + PIPE_LAT] = r;
                if (issued == 0) first_issue_cyc = cyc;
                last_issue_cyc = cyc;
                issued++;
            end
            ov_e = (mq.size() > 0) && (mq[0].avail <= cyc);
            checkOutput("out_valid", out_valid, ov_e);
            if (ov_e) begin
                checkOutput("out_data", out_data, mq[0].data);
                checkOutput("out_last", out_last, mq[0].last);
                if (!seen_valid) begin
                    first_valid_cyc = cyc;
                    seen_valid = 1;
                end
            end
            pop_e = ov_e && out_ready;
            done_e = pop_e && mq[0].last;
            checkOutput("done", done, done_e);
            if (pop_e) begin
                if (mq[0].last) frame_lasts++;
                void'(mq.pop_front());
                popped++;
            end
            if (sched.exists(cyc)) begin
                r = sched[cyc];
                sum_in = r.data;
                r.avail = cyc + 1;
                mq.push_back(r);
                sched.delete(cyc);
            end else begin
                sum_in = OUT_W'($urandom);
            end
`ifdef CONV_SCHED_STALL_CNT_EN
            checkOutput("stall_cnt", stall_cnt, stall_m);
`endif
            if (ms == M_RUN && !issue_e) stall_m++;
            case (ms)
                M_IDLE: if (start) begin
                    ms = M_RUN;
                    issued = 0;
                    popped = 0;
                    stall_m = 0;
                    frame_lasts = 0;
                    seen_valid = 0;
                end
                M_RUN: if (issue_e && issued == NWIN) ms = M_DRAIN;
                M_DRAIN: if (done_e) begin
                    ms = M_IDLE;
                    frames_done++;
                end
                default: ms = M_IDLE;
            endcase
        end
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = spam && busy && ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic startFrame();
        @(posedge clk);
        #1;
        start = 1'b1;
        applyStimulus(1);
    endtask

    task automatic waitDone(input int budget);
        int d0, k;
        d0 = frames_done;
        k = 0;
        while (frames_done == d0 && k < budget) begin
            applyStimulus(1);
            k++;
        end
        checkOutput("frame_done_in_time", frames_done - d0, 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        sum_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        rst = 1'b0;
        applyStimulus(2);

        ready_mode = 1;
        startFrame();
        waitDone(3000);
        checkOutput("f1_issues", issued, 784);
        checkOutput("f1_lasts", frame_lasts, 1);
        checkOutput("f1_first_latency", first_valid_cyc - first_issue_cyc, PIPE_LAT + 1);
        checkOutput("f1_issue_span", last_issue_cyc - first_issue_cyc, 783);
        applyStimulus(1);
        checkOutput("f1_busy_after", busy, 0);

        ready_mode = 0;
        startFrame();
        applyStimulus(40);
        checkOutput("bp_issues", issued, FIFO_DEPTH);
        checkOutput("bp_issue_low", issue, 0);
        checkOutput("bp_head_valid", out_valid, 1);
        ready_mode = 1;
        waitDone(3000);
        checkOutput("bp_total", issued, 784);
        checkOutput("bp_lasts", frame_lasts, 1);

        ready_mode = 2;
        spam = 1;
        startFrame();
        waitDone(6000);
        spam = 0;
        checkOutput("rnd_total", issued, 784);
        checkOutput("rnd_lasts", frame_lasts, 1);

        ready_mode = 1;
        startFrame();
        for (int k = 0; k < 30 && issued < 5; k++) applyStimulus(1);
        checkOutput("pre_rst_issues", issued, 5);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_issue", issue, 0);
        checkOutput("async_rst_win_col", win_col, 0);
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(2);
        startFrame();
        waitDone(3000);
        checkOutput("post_rst_total", issued, 784);
        checkOutput("post_rst_lasts", frame_lasts, 1);
        applyStimulus(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
